// File: rtl/hynoc_pkt_arbiter.sv
// Packet-locking round-robin arbiter for one hynoc output port: a grant is held
// for a whole packet and released on eop, request withdrawal or inactivity timeout.
module hynoc_pkt_arbiter #(
  parameter int NB_REQ        = 4,
  parameter int LOG2_NB_REQ   = 2,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic [NB_REQ-1:0]      request,
  input  logic [NB_REQ-1:0]      write,
  input  logic [NB_REQ-1:0]      eop,
  output logic [NB_REQ-1:0]      grant,
  output logic [LOG2_NB_REQ-1:0] state,
  output logic                   busy,
  output logic                   timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fsm_t;

  // With TIMEOUT=0 this wraps to all ones, so the counter saturates at its maximum.
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [LOG2_NB_REQ-1:0]   IDX_LAST = LOG2_NB_REQ'(NB_REQ - 1);
  localparam logic                     TO_EN    = (TIMEOUT != 0);

  fsm_t                     r_fsm;
  logic [NB_REQ-1:0]        r_grant;
  logic [LOG2_NB_REQ-1:0]   r_state;
  logic [LOG2_NB_REQ-1:0]   r_ptr;
  logic [TIMEOUT_WIDTH-1:0] r_idle_cnt;
  logic                     r_timeout;

  logic                     w_wr_g;
  logic                     w_rel_eop;
  logic                     w_rel_wd;
  logic                     w_rel_to;
  logic                     w_release;
  logic                     w_to_cause;
  logic [LOG2_NB_REQ-1:0]   w_ptr_next;
  logic [LOG2_NB_REQ-1:0]   w_arb_ptr;
  logic [NB_REQ-1:0]        w_arb_req;
  logic [NB_REQ-1:0]        w_g_onehot;
  logic [NB_REQ-1:0]        w_win_onehot;
  logic [LOG2_NB_REQ-1:0]   w_win_idx;
  logic                     w_win_vld;
  logic [LOG2_NB_REQ:0]     w_scan;

  assign w_wr_g     = write[r_state];
  assign w_rel_eop  = w_wr_g & eop[r_state];
  assign w_rel_wd   = ~request[r_state] & ~w_wr_g;
  assign w_rel_to   = TO_EN & ~w_wr_g & (r_idle_cnt == CNT_LAST);
  assign w_release  = (r_fsm == ST_BUSY) & (w_rel_eop | w_rel_wd | w_rel_to);
  assign w_to_cause = (r_fsm == ST_BUSY) & w_rel_to & ~w_rel_eop & ~w_rel_wd;
  assign w_ptr_next = (r_state == IDX_LAST) ? '0 : r_state + 1'b1;
  assign w_g_onehot = NB_REQ'(1) << r_state;

  // On release the scan starts past the old grantee, which is excluded outright.
  assign w_arb_ptr  = (r_fsm == ST_BUSY) ? w_ptr_next : r_ptr;
  assign w_arb_req  = (r_fsm == ST_BUSY) ? (request & ~w_g_onehot) : request;

  // Scan in reverse priority so the last hit is the first in round-robin order.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_scan    = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      w_scan = {1'b0, w_arb_ptr} + (LOG2_NB_REQ + 1)'(i);
      if (w_scan >= (LOG2_NB_REQ + 1)'(NB_REQ)) begin
        w_scan = w_scan - (LOG2_NB_REQ + 1)'(NB_REQ);
      end
      if (w_arb_req[w_scan[LOG2_NB_REQ-1:0]]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan[LOG2_NB_REQ-1:0];
      end
    end
  end

  assign w_win_onehot = NB_REQ'(1) << w_win_idx;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_fsm      <= ST_IDLE;
      r_grant    <= '0;
      r_state    <= '0;
      r_ptr      <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_fsm      <= ST_BUSY;
            r_grant    <= w_win_onehot;
            r_state    <= w_win_idx;
            r_idle_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_ptr     <= w_ptr_next;
            r_timeout <= w_to_cause;
            if (w_win_vld) begin
              r_grant    <= w_win_onehot;
              r_state    <= w_win_idx;
              r_idle_cnt <= '0;
            end else begin
              r_fsm   <= ST_IDLE;
              r_grant <= '0;
            end
          end else if (w_wr_g) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt != CNT_LAST) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign state   = r_state;
  assign busy    = (r_fsm == ST_BUSY);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_hynoc_pkt_arbiter.sv
// Scoreboard bench for hynoc_pkt_arbiter: directed packet scenarios followed by
// randomized traffic, every cycle compared against a high-level reference model.
module tb_hynoc_pkt_arbiter;

  localparam int N  = 4;
  localparam int LW = 2;
  localparam int TW = 8;
  localparam int TO = 4;
  localparam int EW = N + LW + 2;

  // clock / reset
  logic          clk   = 1'b0;
  logic          arstn = 1'b0;
  logic [N-1:0]  request = '0;
  logic [N-1:0]  write   = '0;
  logic [N-1:0]  eop     = '0;
  logic [N-1:0]  grant;
  logic [LW-1:0] state;
  logic          busy;
  logic          timeout;

  always #5 clk = ~clk;

  hynoc_pkt_arbiter #(
    .NB_REQ(N), .LOG2_NB_REQ(LW), .TIMEOUT_WIDTH(TW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .arstn(arstn), .request(request), .write(write), .eop(eop),
    .grant(grant), .state(state), .busy(busy), .timeout(timeout)
  );

  logic [EW-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  // reference model: current grantee, priority pointer, cycles since last activity
  int m_busy = 0;
  int m_g    = 0;
  int m_ptr  = 0;
  int m_idle = 0;
  int m_to   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [LW-1:0] k;
    k = LW'(i);
    return v[k];
  endfunction

  function automatic int scan_first(input int p, input logic [N-1:0] req);
    int order[$];
    for (int k = 0; k < N; k++) order.push_back((p + k) % N);
    foreach (order[j]) if (bit_of(req, order[j])) return order[j];
    return -1;
  endfunction

  function automatic logic [EW-1:0] exp_word();
    logic [N-1:0] g;
    g = (m_busy != 0) ? (N'(1) << m_g) : '0;
    return {g, LW'(m_g), (m_busy != 0), (m_to != 0)};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_ptr = 0; m_idle = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] wr, input logic [N-1:0] ep);
    int w;
    int rel;
    logic [N-1:0] others;
    m_to = 0;
    if (m_busy == 0) begin
      w = scan_first(m_ptr, req);
      if (w >= 0) begin
        m_busy = 1; m_g = w; m_idle = 0;
      end
    end else begin
      rel = 0;
      if (bit_of(wr, m_g) && bit_of(ep, m_g)) rel = 1;
      else if (!bit_of(req, m_g) && !bit_of(wr, m_g)) rel = 1;
      else if (TO != 0 && !bit_of(wr, m_g) && m_idle == TO - 1) begin
        rel = 1; m_to = 1;
      end
      if (rel != 0) begin
        m_ptr = (m_g + 1) % N;
        others = req & ~(N'(1) << m_g);
        w = scan_first(m_ptr, others);
        if (w >= 0) begin
          m_g = w; m_idle = 0;
        end else begin
          m_busy = 0;
        end
      end else if (bit_of(wr, m_g)) begin
        m_idle = 0;
      end else if (m_idle < TO - 1) begin
        m_idle++;
      end
    end
  endtask

  // driver: inputs change on the falling edge; expectation for the next rising edge is queued
  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] wr, input logic [N-1:0] ep);
    @(negedge clk);
    request = req;
    write   = wr;
    eop     = ep;
    model_step(req, wr, ep);
    exp_q.push_back(exp_word());
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    arstn   = 1'b0;
    request = '0;
    write   = '0;
    eop     = '0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    arstn = 1'b1;
  endtask

  // monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", 32'({grant, state, busy, timeout}), 32'(e));
      end
    end
  end

  initial begin
    int rr_order[5];
    int g;
    logic [N-1:0] wr;
    logic [N-1:0] rnd_req;
    int quiet;
    rr_order = '{0, 1, 2, 3, 0};

    #12;
    check("reset_outputs", 32'({grant, state, busy, timeout}), 32'd0);
    @(negedge clk);
    arstn = 1'b1;

    // single request, then packet end
    drive(4'b0010, 4'b0000, 4'b0000);
    check("single_grant", 32'(grant), 32'b0010);
    check("single_state", 32'(state), 32'd1);
    drive(4'b0000, 4'b0010, 4'b0010);
    check("single_release", 32'(grant), 32'd0);
    drive(4'b0000, 4'b0000, 4'b0000);

    // round robin, 3-flit packets, restart from pointer 0
    do_reset();
    drive(4'b1111, 4'b0000, 4'b0000);
    for (int p = 0; p < 5; p++) begin
      check("rr_order", 32'(grant), 32'(N'(1) << rr_order[p]));
      for (int f = 0; f < 3; f++) begin
        g  = m_g;
        wr = N'(1) << g;
        drive(4'b1111, wr, (f == 2) ? wr : 4'b0000);
      end
    end

    // back-to-back rotation between 3 and 0
    drive(4'b1001, 4'b0000, 4'b0000);
    check("b2b_grant3", 32'(grant), 32'b1000);
    drive(4'b1001, 4'b1000, 4'b1000);
    check("b2b_wrap0", 32'(grant), 32'b0001);
    drive(4'b1001, 4'b0001, 4'b0001);
    check("b2b_back3", 32'(grant), 32'b1000);
    drive(4'b1001, 4'b1000, 4'b1000);

    // write/eop from a non-grantee is ignored, then withdrawal
    drive(4'b0001, 4'b1000, 4'b1000);
    check("ignore_other", 32'(grant), 32'b0001);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("withdraw", 32'({grant, timeout}), 32'd0);

    // inactivity timeout
    drive(4'b0100, 4'b0000, 4'b0000);
    check("to_grant2", 32'(grant), 32'b0100);
    repeat (3) drive(4'b0111, 4'b0000, 4'b0000);
    check("to_hold", 32'({grant, timeout}), 32'b01000);
    drive(4'b0111, 4'b0000, 4'b0000);
    check("to_release", 32'({grant, timeout}), 32'b00011);
    drive(4'b0111, 4'b0000, 4'b0000);
    check("to_pulse_end", 32'(timeout), 32'd0);

    // withdrawal mid-packet after a flit
    drive(4'b0010, 4'b0000, 4'b0000);
    drive(4'b0010, 4'b0010, 4'b0000);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("wd_mid_pkt", 32'({grant, timeout}), 32'd0);

    // asynchronous reset mid-packet
    drive(4'b0001, 4'b0000, 4'b0000);
    drive(4'b0001, 4'b0001, 4'b0000);
    do_reset();
    drive(4'b1100, 4'b0000, 4'b0000);
    check("post_rst_grant", 32'({grant, state}), 32'b010010);

    // randomized traffic with occasional quiet phases to provoke timeouts
    rnd_req = N'($urandom);
    quiet   = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 24 == 0) quiet = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) rnd_req[b] = ~rnd_req[b];
      end
      wr = (quiet != 0) ? '0 : N'($urandom);
      drive(rnd_req, wr, N'($urandom) & N'($urandom));
    end

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
